// File: rtl/mem_dump_ctrl.sv
// Memory dump / verification engine: walks a RAM address window after a program
// run and either streams (address, data) beats or accumulates a signature only.
module mem_dump_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h0040_0000,
   parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 32'h0052_0000,
   parameter int                    STRIDE     = 1,
   parameter int                    RD_LATENCY = 1,
   parameter int                    CNT_WIDTH  = 24
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  mode,
   input  logic                  abort,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum,
   output logic [CNT_WIDTH-1:0]  word_count
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_OUT  = 3'd3;
   localparam logic [2:0] S_NEXT = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
   localparam int                    LW       = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [LW-1:0]         LAT_LAST = LW'(RD_LATENCY - 1);

   if (STRIDE < 1) begin : g_bad_stride
      $error("mem_dump_ctrl: STRIDE must be at least 1");
   end
   if (RD_LATENCY < 1) begin : g_bad_latency
      $error("mem_dump_ctrl: RD_LATENCY must be at least 1");
   end

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  mode_q;
   logic [LW-1:0]         lat_cnt;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] sum_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  busy_q;
   logic                  done_q;

   function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
      return a + b;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // Last word when the window end is reached or the next step would pass it;
   // the subtraction form never lets the address wrap past the top of memory,
   // and a start beyond the end terminates after the first word.
   function automatic logic last_word(input logic [ADDR_WIDTH-1:0] a);
      return (a >= END_ADDR) || ((END_ADDR - a) < STRIDE_A);
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= S_IDLE;
         addr    <= '0;
         mode_q  <= 1'b0;
         lat_cnt <= '0;
         data_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if ((state != S_IDLE) && abort) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state  <= S_REQ;
                     addr   <= START_ADDR;
                     sum_q  <= '0;
                     cnt_q  <= '0;
                     mode_q <= mode;
                     busy_q <= 1'b1;
                  end
               end
               S_REQ: begin
                  state   <= S_WAIT;
                  lat_cnt <= '0;
               end
               // read data is valid during the final latency cycle
               S_WAIT: begin
                  if (lat_cnt == LAT_LAST) begin
                     data_q <= mem_rdata;
                     sum_q  <= wrap_add(sum_q, mem_rdata);
                     cnt_q  <= sat_inc(cnt_q);
                     state  <= mode_q ? S_NEXT : S_OUT;
                  end else begin
                     lat_cnt <= lat_cnt + 1'b1;
                  end
               end
               S_OUT: begin
                  if (out_ready) begin
                     state <= S_NEXT;
                  end
               end
               S_NEXT: begin
                  if (last_word(addr)) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     addr  <= addr + STRIDE_A;
                     state <= S_REQ;
                  end
               end
               default: begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mem_rd_en  = (state == S_REQ);
   assign mem_addr   = addr;
   assign out_valid  = (state == S_OUT);
   assign out_addr   = addr;
   assign out_data   = data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign checksum   = sum_q;
   assign word_count = cnt_q;

endmodule
